// File: rtl/fnd_scan_ctrl_if.sv
// Signal bundle between display-value producers and the FND scan controller.
// Signal suffixes follow the controller's view: _i into the scanner, _o out to the board pins.
interface fnd_scan_ctrl_if #(
  parameter int N_DIGITS = 4,
  parameter int BRT_W    = 3
);
  logic                  enable_i;
  logic [4*N_DIGITS-1:0] value_i;
  logic [N_DIGITS-1:0]   dp_i;
  logic [BRT_W-1:0]      brightness_i;
  logic [N_DIGITS-1:0]   com_o;
  logic [7:0]            seg_7_o;
  logic                  frame_done_o;

  modport master (
    output enable_i, value_i, dp_i, brightness_i,
    input  com_o, seg_7_o, frame_done_o
  );

  modport slave (
    input  enable_i, value_i, dp_i, brightness_i,
    output com_o, seg_7_o, frame_done_o
  );
endinterface

// File: rtl/fnd_scan_ctrl.sv
// N-digit multiplexed common-anode 7-segment scanner with blanking gap, PWM brightness and frame-latched value.
// Optional leading-zero suppression is enabled by defining FND_LZ_SUPPRESS_EN.
module fnd_scan_ctrl #(
  parameter int N_DIGITS  = 4,
  parameter int SCAN_LOG2 = 17,
  parameter int BLANK_CYC = 64,
  parameter int BRT_W     = 3
) (
  input logic             clk,
  input logic             rst_n,
  fnd_scan_ctrl_if.slave  scan_if
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);
`ifdef FND_LZ_SUPPRESS_EN
  localparam bit LZ_EN = 1'b1;
`else
  localparam bit LZ_EN = 1'b0;
`endif

  logic [SCAN_LOG2-1:0]  slotCnt_q;
  logic [IDX_W-1:0]      digitIdx_q;
  logic [4*N_DIGITS-1:0] shadowVal_q;
  logic [N_DIGITS-1:0]   shadowDp_q;
  logic [N_DIGITS-1:0]   com_q, com_d;
  logic [7:0]            seg_q, seg_d;
  logic                  frameDone_q, frameDone_d;

  logic                  sampleNow;
  logic [4*N_DIGITS-1:0] valEff;
  logic [N_DIGITS-1:0]   dpEff;
  logic [3:0]            nibble;
  logic                  dpBit;
  logic                  pwmOn;
  logic                  lit;
  logic                  lzRun;
  logic                  suppress;
  logic [6:0]            segFont;

  function automatic logic [6:0] hexFont(input logic [3:0] n);
    case (n)
      4'h0: hexFont = 7'h3F;
      4'h1: hexFont = 7'h06;
      4'h2: hexFont = 7'h5B;
      4'h3: hexFont = 7'h4F;
      4'h4: hexFont = 7'h66;
      4'h5: hexFont = 7'h6D;
      4'h6: hexFont = 7'h7D;
      4'h7: hexFont = 7'h07;
      4'h8: hexFont = 7'h7F;
      4'h9: hexFont = 7'h6F;
      4'hA: hexFont = 7'h77;
      4'hB: hexFont = 7'h7C;
      4'hC: hexFont = 7'h39;
      4'hD: hexFont = 7'h5E;
      4'hE: hexFont = 7'h79;
      4'hF: hexFont = 7'h71;
    endcase
  endfunction

  // At the first cycle of a frame the shadow is being loaded, so decode the live inputs
  // directly; this keeps slot 0 consistent with the value the frame latches.
  always_comb begin
    sampleNow = (slotCnt_q == '0) && (digitIdx_q == '0);
    valEff    = sampleNow ? scan_if.value_i : shadowVal_q;
    dpEff     = sampleNow ? scan_if.dp_i    : shadowDp_q;
    pwmOn     = (&scan_if.brightness_i) ||
                (slotCnt_q[SCAN_LOG2-1 -: BRT_W] < scan_if.brightness_i);
    lit       = (slotCnt_q >= SCAN_LOG2'(BLANK_CYC)) && pwmOn;

    nibble   = 4'h0;
    dpBit    = 1'b0;
    suppress = 1'b0;
    lzRun    = 1'b1;
    com_d    = '1;
    for (int i = 0; i < N_DIGITS; i++) begin
      lzRun = lzRun && (valEff[4*(N_DIGITS-1-i) +: 4] == 4'h0);
      if (digitIdx_q == IDX_W'(i)) begin
        nibble   = valEff[4*(N_DIGITS-1-i) +: 4];
        dpBit    = dpEff[N_DIGITS-1-i];
        suppress = LZ_EN && lzRun && (i != N_DIGITS - 1);
        com_d[i] = ~lit;
      end
    end

    segFont     = suppress ? 7'h00 : hexFont(nibble);
    seg_d       = ~{dpBit, segFont};
    frameDone_d = (digitIdx_q == LAST_IDX) && (&slotCnt_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slotCnt_q   <= '0;
      digitIdx_q  <= '0;
      shadowVal_q <= '0;
      shadowDp_q  <= '0;
      com_q       <= '1;
      seg_q       <= 8'hFF;
      frameDone_q <= 1'b0;
    end else if (!scan_if.enable_i) begin
      slotCnt_q   <= '0;
      digitIdx_q  <= '0;
      com_q       <= '1;
      seg_q       <= 8'hFF;
      frameDone_q <= 1'b0;
    end else begin
      slotCnt_q <= slotCnt_q + 1'b1;
      if (&slotCnt_q) begin
        digitIdx_q <= (digitIdx_q == LAST_IDX) ? '0 : digitIdx_q + 1'b1;
      end
      if (sampleNow) begin
        shadowVal_q <= scan_if.value_i;
        shadowDp_q  <= scan_if.dp_i;
      end
      com_q       <= com_d;
      seg_q       <= seg_d;
      frameDone_q <= frameDone_d;
    end
  end

  assign scan_if.com_o        = com_q;
  assign scan_if.seg_7_o      = seg_q;
  assign scan_if.frame_done_o = frameDone_q;

endmodule
